// File: rtl/alu_exec.sv
// EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops plus an iterative shift-add multiply.
module alu_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             op_err
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1000;

   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             op_err_q, op_err_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_err;
   logic             is_mul;
   logic             slt_lt;
   logic [WIDTH-1:0] acc_step;
   logic             accept;

   // Signed compare is exact regardless of whether A-B would overflow.
   assign slt_lt   = $signed(src_a) < $signed(src_b);
   assign is_mul   = (ALUctrl == OP_MUL);
   assign accept   = in_valid && (state_q == IDLE);
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (ALUctrl)
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_ADD:  alu_res = src_a + src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
         OP_NOR:  alu_res = ~(src_a | src_b);
         OP_MUL:  alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = is_mul ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Datapath: result capture on accept / multiply completion, one shift-add step per BUSY edge.
   always_comb begin
      result_d = result_q;
      zero_d   = zero_q;
      op_err_d = op_err_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (accept) begin
         if (is_mul) begin
            mcand_d  = src_a;
            mplier_d = src_b;
            acc_d    = '0;
            cnt_d    = '0;
         end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            op_err_d = alu_err;
         end
      end else if (state_q == BUSY) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            result_d = acc_step;
            zero_d   = (acc_step == '0);
            op_err_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         op_err_q <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         op_err_q <= op_err_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result = result_q;
   assign zero   = zero_q;
   assign op_err = op_err_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_exec;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       ALUctrl = 4'd0;
   logic [WIDTH-1:0] src_a = '0;
   logic [WIDTH-1:0] src_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             op_err;

   int tests_run = 0;
   int tests_failed = 0;

   alu_exec #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUctrl   (ALUctrl),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 500000");
      $fatal(1, "[TB] timeout");
   end

   // Reference: the ALU's arithmetic rules written as plain arithmetic.
   function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint sa, sb;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      p  = 64'(a) * 64'(b);
      e  = 1'b0;
      case (c)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b1100: r = ~(a | b);
         4'b1000: r = p[31:0];
         default: begin r = 32'd0; e = 1'b1; end
      endcase
   endfunction

   // Drives one op, scrambles inputs after acceptance, waits for the result and consumes it.
   // lat = cycle index (relative to accept edge k) where out_valid is first seen.
   task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic e,
                        output int lat, output logic ready_leak);
      int w;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL accept_wait: in_ready=%b required 1", in_ready);
      end
      in_valid  = 1'b1;
      ALUctrl   = c;
      src_a     = a;
      src_b     = b;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ALUctrl  = 4'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      lat = 1;
      ready_leak = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) ready_leak = 1'b1;
         @(negedge clk);
         lat++;
         ALUctrl  = 4'($urandom);
         src_a    = $urandom;
         src_b    = $urandom;
         in_valid = 1'($urandom_range(0, 1));
      end
      r = result;
      z = zero;
      e = op_err;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      tests_run += 5;
      if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      if (result !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
      if (zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_zero: got %b expected 0", zero); end
      if (op_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_op_err: got %b expected 0", op_err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_wrap();
      logic [31:0] r; logic z, e, leak; int lat;
      do_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, r, z, e, lat, leak);
      tests_run++;
      if (r !== 32'h0 || z !== 1'b1 || e !== 1'b0 || lat != 1) begin
         tests_failed++;
         $display("[TB] FAIL add_wrap: got r=%h z=%b e=%b lat=%0d expected r=0 z=1 e=0 lat=1", r, z, e, lat);
      end
   endtask

   task automatic test_slt_sub();
      logic [31:0] r; logic z, e, leak; int lat;
      do_op(4'b0111, 32'h8000_0000, 32'h0000_0001, r, z, e, lat, leak);
      tests_run++;
      if (r !== 32'h1 || z !== 1'b0 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL slt_overflow: got r=%h z=%b e=%b expected r=1 z=0 e=0", r, z, e);
      end
      do_op(4'b0110, 32'h8000_0000, 32'h0000_0001, r, z, e, lat, leak);
      tests_run++;
      if (r !== 32'h7FFF_FFFF || z !== 1'b0 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL sub_wrap: got r=%h z=%b e=%b expected r=7fffffff z=0 e=0", r, z, e);
      end
   endtask

   task automatic test_mul();
      logic [31:0] r; logic z, e, leak; int lat;
      do_op(4'b1000, 32'h0001_0000, 32'h0001_0001, r, z, e, lat, leak);
      tests_run += 3;
      if (r !== 32'h0001_0000 || z !== 1'b0 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mul_result: got r=%h z=%b e=%b expected r=00010000 z=0 e=0", r, z, e);
      end
      if (lat != WIDTH + 1) begin
         tests_failed++;
         $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, WIDTH + 1);
      end
      if (leak !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mul_busy_ready: in_ready seen %b during BUSY expected 0", leak);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] r; logic z, e, leak; int lat;
      do_op(4'b0011, 32'h1234_5678, 32'h0000_0042, r, z, e, lat, leak);
      tests_run++;
      if (r !== 32'h0 || z !== 1'b1 || e !== 1'b1 || lat != 1) begin
         tests_failed++;
         $display("[TB] FAIL illegal_code: got r=%h z=%b e=%b lat=%0d expected r=0 z=1 e=1 lat=1", r, z, e, lat);
      end
      do_op(4'b0010, 32'd5, 32'd7, r, z, e, lat, leak);
      tests_run++;
      if (r !== 32'd12 || z !== 1'b0 || e !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL illegal_clear: got r=%h z=%b e=%b expected r=c z=0 e=0", r, z, e);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      in_valid = 1'b1; ALUctrl = 4'b0010; src_a = 32'd100; src_b = 32'd23; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (out_valid !== 1'b1 || result !== 32'd123 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_hold[%0d]: got v=%b r=%h rdy=%b expected v=1 r=7b rdy=0",
                     i, out_valid, result, in_ready);
         end
         in_valid = 1'b1;
         ALUctrl  = 4'b0000;
         src_a    = $urandom;
         src_b    = $urandom;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL backpressure_release: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] q[$];
      logic [31:0] a, b, s;
      int got;
      got = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            tests_run++;
            if (q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL b2b_extra: got result %h expected none", result);
            end else begin
               s = q.pop_front();
               if (result !== s) begin
                  tests_failed++;
                  $display("[TB] FAIL b2b_result: got %h expected %h", result, s);
               end
            end
            got++;
         end
         if (in_ready) begin
            a = $urandom; b = $urandom;
            src_a = a; src_b = b; ALUctrl = 4'b0010; in_valid = 1'b1;
            s = a + b;
            q.push_back(s);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tests_run++;
      if (got != 10) begin
         tests_failed++;
         $display("[TB] FAIL b2b_throughput: got %0d results expected 10", got);
      end
   endtask

   task automatic test_random();
      logic [3:0]  legal [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000};
      logic [31:0] sp [4] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
      logic [3:0]  c;
      logic [31:0] a, b, r, er;
      logic        z, e, ee, leak;
      int          lat, elat;
      for (int n = 0; n < 40; n++) begin
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 6)];
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = sp[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) b = sp[$urandom_range(0, 3)];
         model(c, a, b, er, ee);
         elat = (c == 4'b1000) ? WIDTH + 1 : 1;
         do_op(c, a, b, r, z, e, lat, leak);
         tests_run++;
         if (r !== er || z !== (er == 32'd0) || e !== ee || lat != elat || leak !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL random[%0d] op=%b a=%h b=%h: got r=%h z=%b e=%b lat=%0d leak=%b expected r=%h z=%b e=%b lat=%0d leak=0",
                     n, c, a, b, r, z, e, lat, leak, er, (er == 32'd0), ee, elat);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [31:0] r; logic z, e, leak; int lat;
      do_op(4'b0010, 32'd5, 32'd3, r, z, e, lat, leak);
      tests_run++;
      if (r !== 32'd8) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_add: got %h expected 8", r);
      end
      @(negedge clk);
      in_valid = 1'b1; ALUctrl = 4'b1000; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_1234;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1 || zero !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mid_mul_reset: got v=%b r=%h rdy=%b z=%b expected v=0 r=0 rdy=1 z=0",
                  out_valid, result, in_ready, zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'b1000, 32'd7, 32'd6, r, z, e, lat, leak);
      tests_run++;
      if (r !== 32'd42 || z !== 1'b0 || e !== 1'b0 || lat != WIDTH + 1) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_mul: got r=%h z=%b e=%b lat=%0d expected r=2a z=0 e=0 lat=%0d",
                  r, z, e, lat, WIDTH + 1);
      end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_slt_sub();
      test_mul();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
